agc_timepulse_gen: RTL
======================

Name: agc_timepulse_gen

Overview:
- Master timing generator directly upstream of the AGC control unit (ctrl_unit).
- Divides clk into memory cycle times (MCTs) of 12 one-hot timepulses T1..T12 that sequence the control unit's subinstructions.
- Hosts the real-time scaler: TIME1/TIME2 clock counters and a software-loadable TIME3 counter whose overflow raises T3RUPT to the control unit.

Parameters:
- CLK_DIV, 1, clk cycles per timepulse (legal range 1..15).
- MCT_PER_TICK, 8, completed MCTs per scaler tick.
- TIMER_W, 14, width of TIME1, TIME2 and TIME3, matching the AGC 14-bit magnitude.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  enable MCT generation.
- stall  in  1  hold the machine at the next MCT boundary (memory/erasable wait).
- t3_wr  in  1  load TIME3 this cycle.
- t3_wdata  in  TIMER_W  TIME3 load value.
- rupt_ack  in  1  control unit has accepted T3RUPT.
- tp  out  12  one-hot timepulse; bit 0 = T1; all-zero when not running.
- tp_index  out  4  current timepulse number 1..12; 0 when idle.
- mct_start  out  1  high for the first clk cycle of T1.
- mct_done  out  1  high for the last clk cycle of T12.
- time1  out  TIMER_W  low real-time counter.
- time2  out  TIMER_W  high real-time counter.
- time3  out  TIMER_W  interrupt timer.
- t3rupt_req  out  1  level interrupt request.
- running  out  1  high in RUN state.

Behaviour:
- Reset (synchronous, dominant over all inputs): state IDLE; tp=0, tp_index=0, mct_start=0, mct_done=0, time1=time2=time3=0, t3rupt_req=0, running=0, divider=0, scaler=0. Reset mid-MCT aborts the MCT immediately, with no mct_done.
- State IDLE: if run=1, go to RUN. The first T1 cycle appears on the next clk edge with mct_start=1.
- State RUN:
  - Each timepulse lasts exactly CLK_DIV clk cycles, so an MCT lasts 12*CLK_DIV cycles.
  - tp and tp_index change together.
  - mct_start and mct_done are each asserted for exactly 1 cycle per MCT.
- MCT boundary, evaluated on the mct_done cycle:
  - run=0: go to IDLE (outputs zero next cycle).
  - else stall=1: go to HOLD.
  - else: continue at T1.
  - run and stall are ignored mid-MCT; an MCT is never truncated except by reset.
- State HOLD: tp=0, tp_index=0, running=0. When stall=0 and run=1, resume at T1 on the next cycle. When run=0, go to IDLE.
- Scaler:
  - Counts mct_done pulses. On the MCT_PER_TICK-th pulse, issue a tick and clear the scaler.
  - On a tick, time1 increments; on a 2^TIMER_W-1 -> 0 wrap, time2 increments in the same cycle. time2 wraps silently.
- TIME3:
  - Increments on each tick.
  - Wrap 2^TIMER_W-1 -> 0 sets t3rupt_req.
  - t3_wr loads t3_wdata and takes priority over a same-cycle tick; that tick is lost for TIME3 only.
- T3RUPT:
  - t3rupt_req stays high until rupt_ack=1, then clears next cycle.
  - If ack and a new overflow occur in the same cycle, req remains 1.
  - rupt_ack while req=0 has no effect.
- The scaler and timers freeze in IDLE and HOLD, because they only advance on mct_done.

Optional Feature:
- Macro AGC_MCT_COUNTER_EN.
- When defined: adds output port mct_count (32 bits), reset to 0, incremented on every mct_done, wrapping at 2^32.
- When undefined: the port and its register are absent, and all other behaviour is identical.

Test Plan:
- Reset then run=1, CLK_DIV=1 -> tp walks 0x001,0x002,...,0x800 over 12 cycles; mct_start on T1 and mct_done on T12 each for 1 cycle; the sequence repeats.
- CLK_DIV=3 -> each tp value is held for 3 cycles; mct_done high only on cycle 36 of the MCT.
- stall=1 asserted during T5 -> MCT completes through T12, then tp=0; deassert stall after 7 cycles -> T1 is the next cycle, and no timepulse is skipped or repeated.
- MCT_PER_TICK=8 with time1 forced to 16383 via run-time -> after 8 MCTs time1=0 and time2=1 in the same cycle.
- t3_wr with t3_wdata=16383, then one tick -> time3=0 and t3rupt_req=1; rupt_ack pulse -> req=0 the next cycle; t3_wr coincident with a tick -> time3 equals t3_wdata.
- reset asserted at T7 -> the next cycle has tp=0, all counters 0, no mct_done. With AGC_MCT_COUNTER_EN, run 5 MCTs after release -> mct_count=5.

Source files
------------

// File: rtl/agc_timepulse_gen.sv
// AGC master timing: 12-pulse MCT sequencer plus TIME1/TIME2/TIME3 real-time scaler.
// Define AGC_MCT_COUNTER_EN to add the free-running 32-bit mct_count_o output.
module agc_timepulse_gen #(
  parameter int CLK_DIV      = 1,
  parameter int MCT_PER_TICK = 8,
  parameter int TIMER_W      = 14
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               run_i,
  input  logic               stall_i,
  input  logic               t3_wr_i,
  input  logic [TIMER_W-1:0] t3_wdata_i,
  input  logic               rupt_ack_i,
  output logic [11:0]        tp_o,
  output logic [3:0]         tp_index_o,
  output logic               mct_start_o,
  output logic               mct_done_o,
  output logic [TIMER_W-1:0] time1_o,
  output logic [TIMER_W-1:0] time2_o,
  output logic [TIMER_W-1:0] time3_o,
  output logic               t3rupt_req_o,
  output logic               running_o
`ifdef AGC_MCT_COUNTER_EN
  ,
  output logic [31:0]        mct_count_o
`endif
);

  localparam int SCL_W = (MCT_PER_TICK > 1) ? $clog2(MCT_PER_TICK) : 1;
  localparam logic [3:0]         DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [SCL_W-1:0]   SCL_LAST = SCL_W'(MCT_PER_TICK - 1);
  localparam logic [TIMER_W-1:0] T_MAX    = '1;

  // state | meaning: IDLE stopped | RUN sequencing T1..T12 | HOLD stalled at MCT boundary
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_e;

  state_e             state_q, state_d;
  logic [3:0]         div_q, div_d;
  logic [3:0]         idx_q, idx_d;
  logic [SCL_W-1:0]   scl_q, scl_d;
  logic [TIMER_W-1:0] time1_q, time1_d;
  logic [TIMER_W-1:0] time2_q, time2_d;
  logic [TIMER_W-1:0] time3_q, time3_d;
  logic               req_q, req_d;
  logic               running, mct_done, tick, t3_ovf;

  assign running  = (state_q == S_RUN);
  assign mct_done = running && (idx_q == 4'd12) && (div_q == 4'd0);
  assign tick     = mct_done && (scl_q == SCL_LAST);
  assign t3_ovf   = tick && !t3_wr_i && (time3_q == T_MAX);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      scl_q   <= '0;
      time1_q <= '0;
      time2_q <= '0;
      time3_q <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      scl_q   <= scl_d;
      time1_q <= time1_d;
      time2_q <= time2_d;
      time3_q <= time3_d;
      req_q   <= req_d;
    end
  end

  // Divider is a down-counter; a timepulse ends when it reaches zero.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (run_i) begin
          state_d = S_RUN;
          idx_d   = 4'd1;
          div_d   = DIV_LAST;
        end
      end
      S_RUN: begin
        if (div_q != 4'd0) begin
          div_d = div_q - 4'd1;
        end else if (idx_q != 4'd12) begin
          idx_d = idx_q + 4'd1;
          div_d = DIV_LAST;
        end else if (!run_i) begin
          state_d = S_IDLE;
          idx_d   = 4'd0;
        end else if (stall_i) begin
          state_d = S_HOLD;
          idx_d   = 4'd0;
        end else begin
          idx_d = 4'd1;
          div_d = DIV_LAST;
        end
      end
      S_HOLD: begin
        if (!run_i) begin
          state_d = S_IDLE;
        end else if (!stall_i) begin
          state_d = S_RUN;
          idx_d   = 4'd1;
          div_d   = DIV_LAST;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
        div_d   = 4'd0;
      end
    endcase
  end

  // A TIME3 load wins over a same-cycle tick, so no overflow is possible then.
  always_comb begin
    scl_d   = scl_q;
    time1_d = time1_q;
    time2_d = time2_q;
    time3_d = time3_q;
    if (mct_done) scl_d = tick ? '0 : scl_q + SCL_W'(1);
    if (tick) begin
      time1_d = time1_q + TIMER_W'(1);
      if (time1_q == T_MAX) time2_d = time2_q + TIMER_W'(1);
    end
    if (t3_wr_i)   time3_d = t3_wdata_i;
    else if (tick) time3_d = time3_q + TIMER_W'(1);
    req_d = t3_ovf | (req_q & ~rupt_ack_i);
  end

  assign tp_o         = running ? (12'd1 << (idx_q - 4'd1)) : 12'd0;
  assign tp_index_o   = idx_q;
  assign mct_start_o  = running && (idx_q == 4'd1) && (div_q == DIV_LAST);
  assign mct_done_o   = mct_done;
  assign time1_o      = time1_q;
  assign time2_o      = time2_q;
  assign time3_o      = time3_q;
  assign t3rupt_req_o = req_q;
  assign running_o    = running;

`ifdef AGC_MCT_COUNTER_EN
  logic [31:0] mct_count_q;
  always_ff @(posedge clk_i) begin
    if (reset_i)       mct_count_q <= '0;
    else if (mct_done) mct_count_q <= mct_count_q + 32'd1;
  end
  assign mct_count_o = mct_count_q;
`endif

endmodule
